// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared types and constants for the control pipeline unit: FSM states,
// operand/writeback select encodings, RV32 opcode constants and the bundle.
package ctrl_pipe_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_BUBBLE = 2'd1,
        ST_MD_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] RS1_PC   = 2'b00;
    localparam logic [1:0] RS1_REG  = 2'b01;

    localparam logic [1:0] RS2_ZERO = 2'b00;
    localparam logic [1:0] RS2_SIMM = 2'b01;
    localparam logic [1:0] RS2_IIMM = 2'b10;
    localparam logic [1:0] RS2_REG  = 2'b11;

    localparam logic [1:0] WB_PC4   = 2'b00;
    localparam logic [1:0] WB_ALU   = 2'b01;
    localparam logic [1:0] WB_MEM   = 2'b10;
    localparam logic [1:0] WB_UIMM  = 2'b11;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_ADD    = 3'b000;
    localparam logic [2:0] FUNCT3_SR     = 3'b101;

    typedef struct packed {
        logic [1:0] rs1_sel;
        logic [1:0] rs2_sel;
        logic       br_or_jmp;
        logic       use_jalr;
        logic       is_branch;
        logic [1:0] wb_sel;
        logic [2:0] alu_func3;
        logic       alu_func1;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_func;
        logic [4:0] rd;
        logic       muldiv;
        logic       illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Purely combinational RV32I(+M) control decoder: instruction word in,
// control bundle and source register addresses out.
module ctrl_decode
    import ctrl_pipe_unit_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]  i_instruction,
    output ctrl_bundle_t o_bundle,
    output logic [4:0]   o_rs1_addr,
    output logic [4:0]   o_rs2_addr
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_m;

    assign w_opcode   = i_instruction[6:0];
    assign w_funct3   = i_instruction[14:12];
    assign w_funct7   = i_instruction[31:25];
    assign w_is_m     = (w_funct7 == FUNCT7_MULDIV);
    assign o_rs1_addr = i_instruction[19:15];
    assign o_rs2_addr = i_instruction[24:20];

    always_comb begin
        o_bundle = '0;
        case (w_opcode)
            OPC_LUI: begin
                o_bundle.wb_sel    = WB_UIMM;
                o_bundle.reg_write = 1'b1;
            end
            // pc + U-imm: no rs2 encoding exists for U-imm, so the ALU's
            // second operand path is left at its zero select.
            OPC_AUIPC: begin
                o_bundle.rs1_sel   = RS1_PC;
                o_bundle.alu_func3 = FUNCT3_ADD;
                o_bundle.wb_sel    = WB_ALU;
                o_bundle.reg_write = 1'b1;
            end
            OPC_JAL: begin
                o_bundle.br_or_jmp = 1'b1;
                o_bundle.wb_sel    = WB_PC4;
                o_bundle.reg_write = 1'b1;
            end
            OPC_JALR: begin
                o_bundle.rs1_sel   = RS1_REG;
                o_bundle.rs2_sel   = RS2_IIMM;
                o_bundle.alu_func3 = FUNCT3_ADD;
                o_bundle.use_jalr  = 1'b1;
                o_bundle.wb_sel    = WB_PC4;
                o_bundle.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                o_bundle.rs1_sel   = RS1_REG;
                o_bundle.rs2_sel   = RS2_REG;
                o_bundle.is_branch = 1'b1;
                o_bundle.alu_func3 = w_funct3;
            end
            OPC_STORE: begin
                o_bundle.rs1_sel   = RS1_REG;
                o_bundle.rs2_sel   = RS2_SIMM;
                o_bundle.alu_func3 = FUNCT3_ADD;
                o_bundle.mem_write = 1'b1;
                o_bundle.mem_func  = w_funct3;
            end
            OPC_LOAD: begin
                o_bundle.rs1_sel   = RS1_REG;
                o_bundle.rs2_sel   = RS2_IIMM;
                o_bundle.alu_func3 = FUNCT3_ADD;
                o_bundle.mem_read  = 1'b1;
                o_bundle.mem_func  = w_funct3;
                o_bundle.wb_sel    = WB_MEM;
                o_bundle.reg_write = 1'b1;
            end
            OPC_OP: begin
                if (w_is_m && !ENABLE_M) begin
                    o_bundle.illegal = 1'b1;
                end else begin
                    o_bundle.rs1_sel   = RS1_REG;
                    o_bundle.rs2_sel   = RS2_REG;
                    o_bundle.alu_func3 = w_funct3;
                    o_bundle.alu_func1 = i_instruction[30];
                    o_bundle.wb_sel    = WB_ALU;
                    o_bundle.reg_write = 1'b1;
                    o_bundle.muldiv    = w_is_m;
                end
            end
            OPC_OP_IMM: begin
                o_bundle.rs1_sel   = RS1_REG;
                o_bundle.rs2_sel   = RS2_IIMM;
                o_bundle.alu_func3 = w_funct3;
                o_bundle.alu_func1 = (w_funct3 == FUNCT3_SR) ? i_instruction[30] : 1'b0;
                o_bundle.wb_sel    = WB_ALU;
                o_bundle.reg_write = 1'b1;
            end
            default: o_bundle.illegal = 1'b1;
        endcase
        if (o_bundle.reg_write) begin
            o_bundle.rd = i_instruction[11:7];
        end
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Decode pipeline stage: one-deep output register with valid/ready handshake,
// load-use bubble insertion, mul/div occupancy stall and branch flush.
module ctrl_pipe_unit
    import ctrl_pipe_unit_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic        br_taken,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  rs1_sel,
    output logic [1:0]  rs2_sel,
    output logic        br_or_jmp,
    output logic        use_jalr,
    output logic        is_branch,
    output logic [1:0]  wb_sel,
    output logic [2:0]  alu_func3,
    output logic        alu_func1,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_func,
    output logic [4:0]  rd,
    output logic        muldiv,
    output logic        illegal
);

    localparam logic [3:0] MUL_WAIT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_WAIT = 4'(DIV_LAT - 1);

    ctrl_bundle_t w_dec;
    logic [4:0]   w_rs1_addr;
    logic [4:0]   w_rs2_addr;
    ctrl_bundle_t r_bundle;
    logic         r_out_valid;
    state_t       r_state;
    logic [3:0]   r_md_cnt;
    logic         w_lu_hazard;
    logic         w_handoff;
    logic         w_capture;
    logic         w_in_ready;
    logic [3:0]   w_md_load;

    ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_instruction (instruction),
        .o_bundle      (w_dec),
        .o_rs1_addr    (w_rs1_addr),
        .o_rs2_addr    (w_rs2_addr)
    );

    // A load still sitting in the output register cannot forward to the
    // next instruction; the consumer waits one extra cycle behind it.
    assign w_lu_hazard = r_out_valid && r_bundle.mem_read && (r_bundle.rd != 5'd0) &&
                         (((w_dec.rs1_sel == RS1_REG) && (w_rs1_addr == r_bundle.rd)) ||
                          ((w_dec.rs2_sel == RS2_REG) && (w_rs2_addr == r_bundle.rd)));

    assign w_in_ready = !rst && (!r_out_valid || out_ready) && (r_state == ST_RUN) &&
                        !w_lu_hazard && !br_taken;
    assign w_handoff  = r_out_valid && out_ready;
    assign w_capture  = in_valid && w_in_ready;
    assign w_md_load  = r_bundle.alu_func3[2] ? DIV_WAIT : MUL_WAIT;
    assign in_ready   = w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (br_taken) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // The counter holds the remaining stall cycles; leaving MD_WAIT on the
    // cycle it would reach zero gives exactly LAT-1 stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_md_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_handoff && r_bundle.muldiv) begin
                        r_md_cnt <= w_md_load;
                        if (w_md_load != 4'd0) begin
                            r_state <= ST_MD_WAIT;
                        end
                    end else if (w_handoff && w_lu_hazard) begin
                        r_state <= ST_LU_BUBBLE;
                    end
                end
                ST_LU_BUBBLE: r_state <= ST_RUN;
                ST_MD_WAIT: begin
                    r_md_cnt <= r_md_cnt - 4'd1;
                    if (r_md_cnt == 4'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign rs1_sel   = r_bundle.rs1_sel;
    assign rs2_sel   = r_bundle.rs2_sel;
    assign br_or_jmp = r_bundle.br_or_jmp;
    assign use_jalr  = r_bundle.use_jalr;
    assign is_branch = r_bundle.is_branch;
    assign wb_sel    = r_bundle.wb_sel;
    assign alu_func3 = r_bundle.alu_func3;
    assign alu_func1 = r_bundle.alu_func1;
    assign reg_write = r_bundle.reg_write;
    assign mem_read  = r_bundle.mem_read;
    assign mem_write = r_bundle.mem_write;
    assign mem_func  = r_bundle.mem_func;
    assign rd        = r_bundle.rd;
    assign muldiv    = r_bundle.muldiv;
    assign illegal   = r_bundle.illegal;

endmodule
